sign_extender: RTL and testbench

Immediate-extension unit for the MIPS datapath.
- Takes the 16-bit instruction immediate and produces a registered 32-bit operand for the ALU, branch-target adder or LUI path.
- Supports sign and zero extension, plus optional post-extension left shifts (by 2 for branch offsets, by 16 for LUI).
- Sits between instruction decode and the execute-stage operand muxes.

---
 rtl/sign_extender.sv | 54 +++++
 tb/tb_sign_extender.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sign_extender.sv
// Immediate-extension stage: sign/zero-extends the instruction immediate and
// optionally shifts it for branch offsets or LUI, then registers the result.
module sign_extender #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  extend_in,
    input  logic             sign,
    input  logic [1:0]       shift_sel,
    input  logic             in_valid,
    output logic [OUT_W-1:0] extended_out,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_2    = 2'b01,
        SH_16   = 2'b10,
        SH_RSVD = 2'b11
    } shift_e;

    shift_e           shift_mode;
    logic             fill;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] result;

    assign shift_mode = shift_e'(shift_sel);
    assign fill       = sign & extend_in[IN_W-1];
    assign ext        = {{(OUT_W-IN_W){fill}}, extend_in};

    // LUI path builds from the raw immediate, so the extension mode never leaks in
    always_comb begin
        result = ext;
        case (shift_mode)
            SH_2:    result = {ext[OUT_W-3:0], 2'b00};
            SH_16:   result = OUT_W'(extend_in) << 16;
            default: result = ext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            extended_out <= '0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                extended_out <= result;
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// Randomized scoreboard bench for sign_extender: the driver predicts each
// cycle's register state from arithmetic rules; a monitor compares after every edge.
module tb_sign_extender;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] extend_in;
    logic        sign;
    logic [1:0]  shift_sel;
    logic        in_valid;
    logic [31:0] extended_out;
    logic        out_valid;

    sign_extender #(.IN_W(16), .OUT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .extend_in    (extend_in),
        .sign         (sign),
        .shift_sel    (shift_sel),
        .in_valid     (in_valid),
        .extended_out (extended_out),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        vld;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_out = 32'h0;

    // Value semantics: treat the immediate as a number, scale it, wrap mod 2^32
    function automatic logic [31:0] model(logic [15:0] v, logic s, logic [1:0] sh);
        longint val;
        val = (s && v[15]) ? longint'(v) - 65536 : longint'(v);
        if (sh == 2'd1) val = val * 4;
        else if (sh == 2'd2) val = longint'(v) * 65536;
        return val[31:0];
    endfunction

    task automatic drive(string name, logic rst, logic v, logic [15:0] d, logic s, logic [1:0] sh);
        exp_t e;
        @(negedge clk);
        reset = rst; in_valid = v; extend_in = d; sign = s; shift_sel = sh;
        if (rst) model_out = 32'h0;
        else if (v) model_out = model(d, s, sh);
        e.name = name;
        e.data = model_out;
        e.vld  = !rst && v;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (extended_out !== e.data || out_valid !== e.vld) begin
                    errors++;
                    $display("FAIL %s got %h/%b want %h/%b", e.name, extended_out, out_valid, e.data, e.vld);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        reset = 1'b1; in_valid = 1'b0; extend_in = 16'h0; sign = 1'b0; shift_sel = 2'b00;

        drive("reset0", 1, 0, 16'h0, 0, 0);
        drive("reset1", 1, 0, 16'h0, 0, 0);
        drive("idle0",  0, 0, 16'h0, 0, 0);
        drive("idle1",  0, 0, 16'h0, 0, 0);

        drive("zero",       0, 1, 16'h0000, 1, 2'b00);
        drive("mostneg",    0, 1, 16'h8000, 1, 2'b00);
        drive("hold0",      0, 0, 16'h1111, 1, 2'b00);
        drive("hold1",      0, 0, 16'h2222, 0, 2'b01);
        drive("hold2",      0, 0, 16'h3333, 1, 2'b10);
        drive("zext8000",   0, 1, 16'h8000, 0, 2'b00);
        drive("sext7fff",   0, 1, 16'h7FFF, 1, 2'b00);
        drive("sextffff",   0, 1, 16'hFFFF, 1, 2'b00);
        drive("zextffff",   0, 1, 16'hFFFF, 0, 2'b00);
        drive("shl2neg",    0, 1, 16'hFFFE, 1, 2'b01);
        drive("shl2ovf",    0, 1, 16'hC001, 0, 2'b01);
        drive("lui",        0, 1, 16'h1234, 0, 2'b10);
        drive("luisign",    0, 1, 16'h8765, 1, 2'b10);
        drive("rsvd",       0, 1, 16'h8001, 1, 2'b11);
        drive("rstprio",    1, 1, 16'hFFFF, 1, 2'b00);
        drive("postrst",    0, 0, 16'h0, 0, 0);
        drive("aftrst",     0, 1, 16'h8000, 1, 2'b00);

        for (int i = 0; i < 300; i++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0);
            drive("rand", r, 1'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
